// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
//   Deserializer. Qualified serial bits (valid_in=1) are gathered into WIDTH-bit
//   words in a shift register. Each completed word is copied into a separate
//   held output register and offered to a word-oriented consumer.
//   This block is the receive-side partner of the parallel-to-serial
//   transmitter. The transmitter's serial_out and valid_out connect to
//   serial_in and valid_in here.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  0: the first received bit lands in parallel_out[0]
//              1: the first received bit lands in parallel_out[WIDTH-1]
//
// Ports
//   clk           in   1      single clock; all state changes on the rising edge
//   reset         in   1      asynchronous assert, active-low
//   serial_in     in   1      serial data bit
//   valid_in      in   1      serial_in carries a real bit this cycle
//   ready_in      in   1      consumer accepts parallel_out this cycle
//   parallel_out  out  WIDTH  assembled word; stable while valid_out=1
//   valid_out     out  1      a word is available; held until it is accepted
//   busy_out      out  1      a partial word is in progress (1..WIDTH-1 bits held)
//   overrun_out   out  1      sticky; set when a completed word was dropped
//   state_dbg     out  1      assembly FSM state (0 = IDLE, 1 = SHIFT)
//
// Output handshake: a word transfers on a rising edge where valid_out=1 and
//   ready_in=1. While valid_out=1 and no transfer occurs, parallel_out does not
//   change. A word that completes while the output register is full and not
//   transferring is dropped, and overrun_out is set. ready_in is ignored while
//   valid_out=0.
//
// Every output is driven directly from a register, so no input has a
// combinational path to any output.
// -----------------------------------------------------------------------------
module serial_to_parallel #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             valid_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             valid_out,
  output logic             busy_out,
  output logic             overrun_out,
  output logic [0:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // Assembly state
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] sh_q,    sh_d;

  // Output register state
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;

  // The shift register with the current serial bit already inserted.
  logic [WIDTH-1:0] sh_shifted;
  logic             word_done;

  // The shift direction sets the bit placement, so no reversal is needed after
  // capture. For LSB-first, new bits enter at the top and move down. After
  // WIDTH bits, the first bit is in bit 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sh_shifted = {sh_q[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
      assign sh_shifted = {serial_in, sh_q[WIDTH-1:1]};
    end
  endgenerate

  // Assembly FSM. When valid_in=0, the state, count and partial word are all
  // held, so a gap never aborts a word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    word_done = 1'b0;
    if (valid_in) begin
      sh_d = sh_shifted;
      case (state_q)
        S_IDLE: begin
          cnt_d   = ONE_CNT;
          state_d = S_SHIFT;
        end
        default: begin
          if (cnt_q == LAST_CNT) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end
      endcase
    end
  end

  // Output register. A completing word takes priority over the plain
  // "transfer, go empty" case. This lets back-to-back words stream with no
  // bubble when the consumer takes the old word on the same edge.
  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (word_done) begin
      if (!vld_q || ready_in) begin
        out_d = sh_shifted;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && ready_in) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = out_q;
  assign valid_out    = vld_q;
  assign busy_out     = (state_q == S_SHIFT);
  assign overrun_out  = ovr_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel
//   Directed bench for serial_to_parallel. Instance u_lsb is WIDTH=4,
//   LSB-first. Instance u_msb is WIDTH=4, MSB-first. Both instances share all
//   inputs. Inputs change 1 ns after the rising edge, and outputs are checked
//   at that same point, after they have settled.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         serial_in;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] par_a, par_b;
  logic         vld_a, vld_b;
  logic         busy_a, busy_b;
  logic         ovr_a, ovr_b;
  logic [0:0]   st_a, st_b;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic         lb_en = 1'b0;
  int           lb_got = 0;

  serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .valid_in(valid_in),
    .ready_in(ready_in), .parallel_out(par_a), .valid_out(vld_a),
    .busy_out(busy_a), .overrun_out(ovr_a), .state_dbg(st_a)
  );

  serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .valid_in(valid_in),
    .ready_in(ready_in), .parallel_out(par_b), .valid_out(vld_b),
    .busy_out(busy_b), .overrun_out(ovr_b), .state_dbg(st_b)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- loopback scoreboard ----------------
  always @(negedge clk) begin
    if (lb_en && vld_a) begin
      if (exp_q.size() == 0) begin
        chk("lb_unexpected_word", 32'(par_a), 32'hFFFF_FFFF);
      end else begin
        chk("lb_word", 32'(par_a), 32'(exp_q.pop_front()));
      end
      lb_got++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] nib;

    reset     = 1'b0;
    serial_in = 1'b0;
    valid_in  = 1'b0;
    ready_in  = 1'b0;

    // 1: reset held for 3 cycles, then released
    #1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_par",     32'(par_a),  32'h0);
    chk("rst_valid",   32'(vld_a),  32'h0);
    chk("rst_busy",    32'(busy_a), 32'h0);
    chk("rst_overrun", 32'(ovr_a),  32'h0);
    reset = 1'b1;
    tick();
    chk("rel_valid", 32'(vld_a),  32'h0);
    chk("rel_busy",  32'(busy_a), 32'h0);
    chk("rel_par",   32'(par_a),  32'h0);

    // 2: 0,1,0,1 on consecutive cycles -> 4'hA
    ready_in = 1'b1;
    send_bit(1'b0);
    chk("s2_busy1", 32'(busy_a), 32'h1);
    chk("s2_vld1",  32'(vld_a),  32'h0);
    send_bit(1'b1);
    chk("s2_busy2", 32'(busy_a), 32'h1);
    send_bit(1'b0);
    chk("s2_busy3", 32'(busy_a), 32'h1);
    send_bit(1'b1);
    chk("s2_valid", 32'(vld_a),  32'h1);
    chk("s2_par",   32'(par_a),  32'hA);
    chk("s2_busy4", 32'(busy_a), 32'h0);
    idle(1);
    chk("s2_valid_drop", 32'(vld_a), 32'h0);

    // 3: 1,1,0,1 with 2 idle cycles between bits -> 4'hB
    send_bit(1'b1);
    idle(2);
    chk("s3_busy_gap1", 32'(busy_a), 32'h1);
    chk("s3_vld_gap1",  32'(vld_a),  32'h0);
    send_bit(1'b1);
    idle(2);
    chk("s3_busy_gap2", 32'(busy_a), 32'h1);
    send_bit(1'b0);
    idle(2);
    chk("s3_busy_gap3", 32'(busy_a), 32'h1);
    chk("s3_vld_gap3",  32'(vld_a),  32'h0);
    send_bit(1'b1);
    chk("s3_valid", 32'(vld_a), 32'h1);
    chk("s3_par",   32'(par_a), 32'hB);
    idle(1);
    chk("s3_valid_drop", 32'(vld_a), 32'h0);

    // 4: backpressure. 4'h3 is held, 4'hC is dropped.
    ready_in = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("s4_valid3", 32'(vld_a), 32'h1);
    chk("s4_par3",   32'(par_a), 32'h3);
    idle(2);
    chk("s4_hold_valid", 32'(vld_a), 32'h1);
    chk("s4_hold_par",   32'(par_a), 32'h3);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("s4_overrun",   32'(ovr_a), 32'h1);
    chk("s4_par_kept",  32'(par_a), 32'h3);
    chk("s4_vld_kept",  32'(vld_a), 32'h1);
    ready_in = 1'b1;
    tick();
    chk("s4_accept_vld", 32'(vld_a), 32'h0);
    chk("s4_sticky",     32'(ovr_a), 32'h1);
    idle(2);
    chk("s4_sticky2",    32'(ovr_a), 32'h1);

    // 5: back-to-back 4'h5 then 4'h9 with ready_in=1, after a clean reset
    do_reset();
    chk("s5_ovr_cleared", 32'(ovr_a), 32'h0);
    ready_in = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("s5_valid5", 32'(vld_a), 32'h1);
    chk("s5_par5",   32'(par_a), 32'h5);
    send_bit(1'b1);
    chk("s5_mid_vld", 32'(vld_a), 32'h0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("s5_valid9", 32'(vld_a), 32'h1);
    chk("s5_par9",   32'(par_a), 32'h9);
    chk("s5_no_ovr", 32'(ovr_a), 32'h0);
    idle(1);
    chk("s5_drop", 32'(vld_a), 32'h0);

    // 5b: a word completes on the same edge the held word transfers.
    //     The new word loads with no bubble and no overrun.
    ready_in = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("s5b_held5", 32'(par_a), 32'h5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    ready_in = 1'b1;
    send_bit(1'b1);
    chk("s5b_valid", 32'(vld_a), 32'h1);
    chk("s5b_par9",  32'(par_a), 32'h9);
    chk("s5b_no_ovr", 32'(ovr_a), 32'h0);
    idle(1);
    chk("s5b_drop", 32'(vld_a), 32'h0);

    // 6: reset mid-word after 2 bits, then 1,0,0,0. LSB-first gives 1, MSB-first gives 8.
    send_bit(1'b1); send_bit(1'b1);
    chk("s6_busy_pre", 32'(busy_a), 32'h1);
    reset = 1'b0;
    #1;
    chk("s6_async_busy", 32'(busy_a), 32'h0);
    tick();
    reset = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("s6_not_yet", 32'(vld_a), 32'h0);
    send_bit(1'b0);
    chk("s6_lsb_valid", 32'(vld_a), 32'h1);
    chk("s6_lsb_par",   32'(par_a), 32'h1);
    chk("s6_msb_valid", 32'(vld_b), 32'h1);
    chk("s6_msb_par",   32'(par_b), 32'h8);
    idle(1);

    // 7: loopback. 32 random nibbles from a transmitter model (LSB-first),
    //    with random idle gaps between bits.
    do_reset();
    ready_in = 1'b1;
    lb_en    = 1'b1;
    for (int w = 0; w < 32; w++) begin
      nib = W'($urandom_range(0, 15));
      exp_q.push_back(nib);
      for (int b = 0; b < W; b++) begin
        send_bit(nib[b]);
        idle($urandom_range(0, 2));
      end
    end
    idle(3);
    lb_en = 1'b0;
    chk("lb_count",   32'(lb_got),       32'd32);
    chk("lb_q_empty", 32'(exp_q.size()), 32'd0);
    chk("lb_no_ovr",  32'(ovr_a),        32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
